prog_sequencer: RTL and testbench

Parametrised program sequencer for the 9-bit-ISA processor. It replaces the fixed program counter, the hard-wired jump lookup table and the `prog_ctr == 128` done compare. It adds four things:
- a `req`/`done` start handshake with a selectable program entry point;
- a run-time writable jump-target table;
- stall and halt handling;
- a per-run cycle counter.

It sits between the control decoder and `instr_ROM`, and drives `prog_ctr` to the ROM.

---
 rtl/sequencer_pkg.sv | 21 ++
 rtl/jump_lut.sv | 48 ++++
 rtl/prog_sequencer.sv | 155 +++++++++++++++
 tb/tb_prog_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sequencer_pkg.sv
// ---------------------------------------------------------------------------
// sequencer_pkg
// Shared types and default sizing for the program sequencer and its jump
// table.
//   seq_state_t : sequencer FSM state (IDLE / RUN / DONE)
//   DEF_*       : default parameter values for D, LW, NPROG, CW
// ---------------------------------------------------------------------------
package sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  localparam int DEF_D     = 12;
  localparam int DEF_LW    = 3;
  localparam int DEF_NPROG = 3;
  localparam int DEF_CW    = 16;

endpackage

// File: rtl/jump_lut.sv
// ---------------------------------------------------------------------------
// jump_lut
// 2^LW x D jump-target table. It has one synchronous write port and two
// combinational read ports. An asynchronous active-low reset clears every
// entry to zero. A read of the entry being written in the same cycle returns
// the old contents.
// Ports:
//   clk     : clock, rising edge
//   reset   : asynchronous active-low clear
//   we      : write enable
//   waddr   : write index
//   wdata   : write data
//   ridx_a  : read index A (jump index)
//   rdata_a : read data A
//   ridx_b  : read index B (program entry select)
//   rdata_b : read data B
// ---------------------------------------------------------------------------
module jump_lut #(
  parameter int D  = 12,
  parameter int LW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [LW-1:0] waddr,
  input  logic [D-1:0]  wdata,
  input  logic [LW-1:0] ridx_a,
  output logic [D-1:0]  rdata_a,
  input  logic [LW-1:0] ridx_b,
  output logic [D-1:0]  rdata_b
);

  localparam int NE = 2 ** LW;

  logic [D-1:0] tbl [NE];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NE; i++) tbl[i] <= '0;
    end else if (we) begin
      tbl[waddr] <= wdata;
    end
  end

  assign rdata_a = tbl[ridx_a];
  assign rdata_b = tbl[ridx_b];

endmodule

// File: rtl/prog_sequencer.sv
// ---------------------------------------------------------------------------
// prog_sequencer
// Program sequencer for the 9-bit-ISA processor. It drives the instruction
// ROM address from a PC register.
//   - A req/done handshake starts a run at a table-selected entry point.
//   - Absolute and relative jumps resolve through a writable target table.
//   - Stall and halt are handled in the RUN state.
//   - A saturating counter tracks the cycles spent in RUN.
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous active-low reset
//   req        : start request (sampled in IDLE/DONE)
//   prog_sel   : program entry select (out of range selects entry 0)
//   stall      : freeze sequencing this cycle
//   halt       : halt instruction at current prog_ctr
//   absjump_en : jump to table[lut_idx]
//   reljump_en : jump by signed table[lut_idx]
//   lut_idx    : jump-table read index
//   lut_we     : jump-table write enable
//   lut_waddr  : jump-table write index
//   lut_wdata  : jump-table write data
//   prog_ctr   : instruction address
//   running    : high in RUN
//   done       : high in DONE
//   cyc_cnt    : RUN cycles of the current or last run
// ---------------------------------------------------------------------------
module prog_sequencer
  import sequencer_pkg::*;
#(
  parameter int D     = DEF_D,
  parameter int LW    = DEF_LW,
  parameter int NPROG = DEF_NPROG,
  parameter int CW    = DEF_CW
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        req,
  input  logic [((NPROG > 1) ? $clog2(NPROG) : 1)-1:0] prog_sel,
  input  logic                                        stall,
  input  logic                                        halt,
  input  logic                                        absjump_en,
  input  logic                                        reljump_en,
  input  logic [LW-1:0]                               lut_idx,
  input  logic                                        lut_we,
  input  logic [LW-1:0]                               lut_waddr,
  input  logic [D-1:0]                                lut_wdata,
  output logic [D-1:0]                                prog_ctr,
  output logic                                        running,
  output logic                                        done,
  output logic [CW-1:0]                               cyc_cnt
);

  function automatic logic [CW-1:0] sat_inc_cnt(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  seq_state_t state_q, state_nxt;

  logic [D-1:0]  pc_q, pc_nxt;
  logic [CW-1:0] cnt_q, cnt_nxt;
  logic [LW-1:0] sel_idx;
  logic [D-1:0]  jmp_tgt;
  logic [D-1:0]  entry_pc;

  logic signed [D-1:0] pc_s;
  logic signed [D-1:0] off_s;
  logic signed [D-1:0] rel_sum_s;

  // Out-of-range program selects fall back to entry 0.
  always_comb begin
    sel_idx = '0;
    if (int'(prog_sel) < NPROG) sel_idx = LW'(prog_sel);
  end

  jump_lut #(
    .D  (D),
    .LW (LW)
  ) u_lut (
    .clk     (clk),
    .reset   (reset),
    .we      (lut_we),
    .waddr   (lut_waddr),
    .wdata   (lut_wdata),
    .ridx_a  (lut_idx),
    .rdata_a (jmp_tgt),
    .ridx_b  (sel_idx),
    .rdata_b (entry_pc)
  );

  assign pc_s      = signed'(pc_q);
  assign off_s     = signed'(jmp_tgt);
  assign rel_sum_s = pc_s + off_s;

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE, DONE: if (req) state_nxt = RUN;
      RUN:        if (!stall && halt) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // FSM outputs: plain decodes of the state register
  always_comb begin
    running = (state_q == RUN);
    done    = (state_q == DONE);
  end

  // Next-PC and cycle-counter selection
  always_comb begin
    pc_nxt  = pc_q;
    cnt_nxt = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (req) begin
          pc_nxt  = entry_pc;
          cnt_nxt = '0;
        end
      end
      RUN: begin
        cnt_nxt = sat_inc_cnt(cnt_q);
        if (stall || halt) pc_nxt = pc_q;
        else if (absjump_en) pc_nxt = jmp_tgt;
        else if (reljump_en) pc_nxt = unsigned'(rel_sum_s);
        else                 pc_nxt = pc_q + D'(1);
      end
      default: begin
        pc_nxt  = pc_q;
        cnt_nxt = cnt_q;
      end
    endcase
  end

  // PC and counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q  <= '0;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  assign prog_ctr = pc_q;
  assign cyc_cnt  = cnt_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// ---------------------------------------------------------------------------
// tb_prog_sequencer
// Self-checking bench for prog_sequencer (default parameters).
// A behavioural model predicts each cycle's outputs. The prediction is queued
// when the stimulus is applied, then popped and compared after the clock
// edge. Directed checks pin down the key addresses.
// ---------------------------------------------------------------------------
module tb_prog_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic [1:0]  prog_sel = '0;
  logic        stall = 1'b0;
  logic        halt = 1'b0;
  logic        absjump_en = 1'b0;
  logic        reljump_en = 1'b0;
  logic [2:0]  lut_idx = '0;
  logic        lut_we = 1'b0;
  logic [2:0]  lut_waddr = '0;
  logic [11:0] lut_wdata = '0;
  logic [11:0] prog_ctr;
  logic        running;
  logic        done;
  logic [15:0] cyc_cnt;

  prog_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .prog_sel   (prog_sel),
    .stall      (stall),
    .halt       (halt),
    .absjump_en (absjump_en),
    .reljump_en (reljump_en),
    .lut_idx    (lut_idx),
    .lut_we     (lut_we),
    .lut_waddr  (lut_waddr),
    .lut_wdata  (lut_wdata),
    .prog_ctr   (prog_ctr),
    .running    (running),
    .done       (done),
    .cyc_cnt    (cyc_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] pc;
    logic        run;
    logic        dn;
    logic [15:0] cnt;
  } exp_t;

  exp_t sbq[$];

  int n_chk = 0;
  int n_bad = 0;

  // model state: 0 idle, 1 run, 2 done
  logic [11:0] m_tbl [8];
  logic [11:0] m_pc;
  logic [15:0] m_cnt;
  int          m_st;
  logic [15:0] c0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_tbl[i] = '0;
    m_pc  = '0;
    m_cnt = '0;
    m_st  = 0;
  endtask

  task automatic model_step();
    logic [11:0] npc;
    logic [15:0] ncnt;
    int          nst;
    logic [11:0] entry;
    exp_t        e;
    npc   = m_pc;
    ncnt  = m_cnt;
    nst   = m_st;
    entry = (prog_sel >= 2'd3) ? m_tbl[0] : m_tbl[prog_sel];
    if (m_st != 1) begin
      if (req) begin
        npc  = entry;
        ncnt = '0;
        nst  = 1;
      end
    end else begin
      ncnt = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
      if (stall) begin
      end else if (halt) nst = 2;
      else if (absjump_en) npc = m_tbl[lut_idx];
      else if (reljump_en) npc = m_pc + m_tbl[lut_idx];
      else npc = m_pc + 12'd1;
    end
    if (lut_we) m_tbl[lut_waddr] = lut_wdata;
    m_pc  = npc;
    m_cnt = ncnt;
    m_st  = nst;
    e.pc  = npc;
    e.run = (nst == 1);
    e.dn  = (nst == 2);
    e.cnt = ncnt;
    sbq.push_back(e);
  endtask

  // One clock: predict, let the edge happen, then compare away from the edge.
  task automatic tick(input string tag);
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      chk({tag, "_sbq_empty"}, 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      chk({tag, "_pc"},  32'(prog_ctr), 32'(e.pc));
      chk({tag, "_run"}, 32'(running),  32'(e.run));
      chk({tag, "_done"}, 32'(done),    32'(e.dn));
      chk({tag, "_cnt"}, 32'(cyc_cnt),  32'(e.cnt));
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [11:0] d, input string tag);
    lut_we    = 1'b1;
    lut_waddr = a;
    lut_wdata = d;
    tick(tag);
    lut_we    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #3;
    chk("rst_pc",   32'(prog_ctr), 32'h0);
    chk("rst_run",  32'(running),  32'h0);
    chk("rst_done", 32'(done),     32'h0);
    chk("rst_cnt",  32'(cyc_cnt),  32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // 1: entry point and increment
    wr(3'd0, 12'h010, "wr0");
    req = 1'b1; prog_sel = 2'd0;
    tick("start0");
    req = 1'b0;
    chk("entry_pc",  32'(prog_ctr), 32'h010);
    chk("entry_run", 32'(running),  32'h1);
    for (int i = 0; i < 3; i++) tick("inc");
    chk("inc3_pc",  32'(prog_ctr), 32'h013);
    chk("inc3_cnt", 32'(cyc_cnt),  32'd3);

    // 2: relative jump backwards, absolute jump to top then wrap
    stall = 1'b1;
    wr(3'd5, 12'hFFE, "wr5");
    stall = 1'b0;
    reljump_en = 1'b1; lut_idx = 3'd5;
    tick("rel");
    reljump_en = 1'b0;
    chk("rel_pc", 32'(prog_ctr), 32'h011);
    stall = 1'b1;
    wr(3'd3, 12'hFFF, "wr3");
    stall = 1'b0;
    absjump_en = 1'b1; lut_idx = 3'd3;
    tick("abs");
    absjump_en = 1'b0;
    chk("abs_pc", 32'(prog_ctr), 32'hFFF);
    tick("wrap");
    chk("wrap_pc", 32'(prog_ctr), 32'h000);

    // 3: abs beats rel; stall beats both
    stall = 1'b1;
    wr(3'd1, 12'h100, "wr1");
    wr(3'd2, 12'h004, "wr2");
    stall = 1'b0;
    absjump_en = 1'b1; reljump_en = 1'b1; lut_idx = 3'd1;
    tick("both");
    chk("prio_pc", 32'(prog_ctr), 32'h100);
    stall = 1'b1;
    tick("both_stall");
    chk("stall_pc", 32'(prog_ctr), 32'h100);
    stall = 1'b0; absjump_en = 1'b0; reljump_en = 1'b0;
    tick("inc101");

    // 4: halt held under stall
    c0 = m_cnt;
    halt = 1'b1; stall = 1'b1;
    tick("hstall");
    tick("hstall");
    chk("hstall_run", 32'(running), 32'h1);
    chk("hstall_cnt", 32'(cyc_cnt), 32'(c0 + 16'd2));
    stall = 1'b0;
    tick("halt");
    chk("halt_done", 32'(done),     32'h1);
    chk("halt_run",  32'(running),  32'h0);
    chk("halt_pc",   32'(prog_ctr), 32'h101);
    halt = 1'b0;
    tick("dhold");
    tick("dhold");
    chk("dhold_pc",  32'(prog_ctr), 32'h101);
    chk("dhold_cnt", 32'(cyc_cnt),  32'(c0 + 16'd3));
    req = 1'b1; prog_sel = 2'd1;
    tick("restart1");
    req = 1'b0;
    chk("restart_pc",  32'(prog_ctr), 32'h100);
    chk("restart_cnt", 32'(cyc_cnt),  32'h0);

    // 5: write/read collision on entry, out-of-range select
    halt = 1'b1; tick("h5a"); halt = 1'b0;
    lut_we = 1'b1; lut_waddr = 3'd2; lut_wdata = 12'h0AA;
    req = 1'b1; prog_sel = 2'd2;
    tick("coll");
    lut_we = 1'b0; req = 1'b0;
    chk("coll_pc", 32'(prog_ctr), 32'h004);
    halt = 1'b1; tick("h5b"); halt = 1'b0;
    req = 1'b1; prog_sel = 2'd3;
    tick("sel3");
    req = 1'b0;
    chk("sel3_pc", 32'(prog_ctr), 32'h010);
    halt = 1'b1; tick("h5c"); halt = 1'b0;
    req = 1'b1; prog_sel = 2'd2;
    tick("sel2new");
    req = 1'b0;
    chk("sel2new_pc", 32'(prog_ctr), 32'h0AA);
    tick("run5");
    tick("run5");

    // 6: asynchronous reset mid-run
    #2;
    reset = 1'b0;
    #1;
    chk("arst_pc",   32'(prog_ctr), 32'h0);
    chk("arst_run",  32'(running),  32'h0);
    chk("arst_done", 32'(done),     32'h0);
    chk("arst_cnt",  32'(cyc_cnt),  32'h0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick("post_idle");
    req = 1'b1; prog_sel = 2'd2;
    tick("post_req");
    req = 1'b0;
    chk("post_entry", 32'(prog_ctr), 32'h0);
    tick("post_inc");
    tick("post_inc");
    absjump_en = 1'b1; lut_idx = 3'd5;
    tick("post_abs");
    absjump_en = 1'b0;
    chk("post_abs_pc", 32'(prog_ctr), 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
